// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampled asynchronous serial receiver (start, N data bits
//               MSB first, optional parity, 1 or 2 stop bits).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int N      = 8,
    parameter int M      = 3,
    parameter int OVS    = 16,
    parameter int OVS_W  = 4,
    parameter int PARITY = 0,
    parameter int STOP   = 0
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         rxd,
    output logic [N-1:0] data,
    output logic         valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [OVS_W-1:0] c_half_m1   = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0] c_full_m1   = OVS_W'(OVS - 1);
    localparam logic [M-1:0]     c_last_bit  = M'(N - 1);
    localparam logic             c_has_par   = (PARITY != 0);
    localparam logic             c_stop_last = (STOP != 0);

    state_t             r_state;
    state_t             w_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [OVS_W-1:0]   r_ovs_cnt;
    logic [M-1:0]       r_bit_cnt;
    logic               r_stop_cnt;
    logic [N-1:0]       r_shift;
    logic               r_par_err;
    logic               r_frm_err;
    logic               w_rxd_s;
    logic               w_fall;
    logic               w_half;
    logic               w_full;
    logic               w_done;
    logic               w_par_exp;

    assign w_rxd_s = r_sync2;
    assign w_fall  = r_prev & ~r_sync2;
    assign w_half  = (r_ovs_cnt == c_half_m1);
    assign w_full  = (r_ovs_cnt == c_full_m1);
    assign busy    = (r_state != S_IDLE);

    // Synchroniser and edge-detect history idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    generate
        if (PARITY == 1) begin : g_par_even
            assign w_par_exp = ^r_shift;
        end else if (PARITY == 2) begin : g_par_odd
            assign w_par_exp = ~^r_shift;
        end else if (PARITY == 3) begin : g_par_mark
            assign w_par_exp = 1'b1;
        end else begin : g_par_space
            assign w_par_exp = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_next = w_rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full && (r_bit_cnt == c_last_bit)) begin
                    w_next = c_has_par ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_full) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_full && (r_stop_cnt == c_stop_last)) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counter restarts on every state change and every bit midpoint, giving one sample per OVS
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ovs_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if ((r_state == S_IDLE) || (w_next != r_state) || w_full) begin
                r_ovs_cnt <= '0;
            end else begin
                r_ovs_cnt <= r_ovs_cnt + 1'b1;
            end
            case (r_state)
                S_START: begin
                    if (w_half) begin
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_frm_err  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_shift   <= {r_shift[N-2:0], w_rxd_s};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_full) begin
                        r_par_err <= (w_rxd_s != w_par_exp);
                    end
                end
                S_STOP: begin
                    if (w_full) begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                        if (!w_rxd_s) begin
                            r_frm_err <= 1'b1;
                        end
                        if (w_done) begin
                            data       <= r_shift;
                            parity_err <= r_par_err;
                            frame_err  <= r_frm_err | ~w_rxd_s;
                            valid      <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, the counterpart of the team's UART transmitter. It deserialises frames made of a start bit, N data bits (MSB first), optional parity, and 1 or 2 stop bits. Line timing comes from an oversampled clock (clk = OVS × bit rate). Each completed word is presented on a parallel bus with a one-cycle valid strobe and per-frame error flags, for consumption by the host-side logic.

Parameters:
N, 8, data word width.
M, 3, data bit counter width; must satisfy 2^M >= N.
OVS, 16, clk cycles per bit; even, >= 4.
OVS_W, 4, oversample counter width; must satisfy 2^OVS_W >= OVS.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space.
STOP, 0, stop bits: 0 means 1 stop bit, 1 means 2 stop bits.

Ports:
clk  in  1  oversample clock; all logic on posedge.
nrst  in  1  asynchronous active-low reset.
rxd  in  1  serial line, asynchronous to clk; idles high.
data  out  N  last received word; held until the next valid.
valid  out  1  one-cycle strobe when data and the error flags update.
parity_err  out  1  parity mismatch on the last frame; always 0 when PARITY=0.
frame_err  out  1  a stop bit was sampled low on the last frame.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: data=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE.
  - Both synchroniser flops and the previous-sample flop reset to 1, so no false edge is seen after reset.
- Clocking: reset is asynchronous, clock is clk.
- Input path: rxd passes through a 2-flop synchroniser to give rxd_s. All decisions use rxd_s.
- State IDLE:
  - Falling edge of rxd_s (previous sample 1, current 0) → go to START and clear the OVS counter.
  - Otherwise remain in IDLE.
- State START: counts OVS/2 cycles to the bit midpoint.
  - If rxd_s=0 at the midpoint: clear the counter and bit counter, go to DATA.
  - Otherwise (glitch): return to IDLE with no strobe and no flag change.
- State DATA:
  - Sample every OVS cycles, i.e. at each bit midpoint.
  - Shift register left, with the new bit entering bit 0; the first received bit ends up in data[N-1].
  - After the N-th sample: go to PARITY if PARITY≠0, else go to STOP.
- State PARITY: sample one bit at its midpoint. Expected value:
  - even: XOR of the data bits;
  - odd: its inverse;
  - mark: 1;
  - space: 0.
  - A mismatch sets the internal parity_err flag. Then go to STOP.
- State STOP: sample STOP+1 bits at their midpoints. Any sample equal to 0 sets the internal frame_err flag.
  - On the cycle after the last stop-bit midpoint sample:
    - data, parity_err and frame_err are loaded;
    - valid=1 for exactly one cycle;
    - state returns to IDLE.
  - The frame is delivered even when errors are present.
- Latency: valid rises 1 clk after the last stop-bit midpoint sample, i.e. about (1 + N + P + STOP + 0.5)·OVS + 3 clk after the start-bit falling edge reaches rxd, where P = (PARITY≠0).
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start edge that immediately follows the stop bit is caught. There is no minimum idle time.
- Break / low stop: if the line stays low after a frame_err, no new falling edge occurs. The receiver waits in IDLE until the line goes high and then falls again.
- No backpressure: the consumer must capture data on valid. A subsequent frame overwrites it.
- nrst asserted mid-frame: the partial frame is discarded immediately, no valid is produced, and all outputs take their reset values.
- busy is 1 in START, DATA, PARITY and STOP.

Test Plan:
- Nominal frame, PARITY=0, STOP=0, OVS=16: send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → exactly one valid, data=0xA5, parity_err=0, frame_err=0, busy falls with valid.
- Glitch: rxd low for 4 clk, then high → busy high for ≤ 8 clk and back to IDLE; no valid; data and flags unchanged.
- Framing error: send 0x3C with the stop bit driven 0, then line high → valid, data=0x3C, frame_err=1. Next good frame 0x55 → frame_err=0.
- Parity, PARITY=1: send 0x07 with parity bit 1 → parity_err=0. Send 0x07 with parity bit 0 → parity_err=1, data=0x07. Repeat with PARITY=2 and check the inverse results.
- Back-to-back, STOP=1: send 0x00 then 0xFF with zero idle gap → two valids, data 0x00 then 0xFF; frame_err=0 on both; a low second stop bit sets frame_err.
- Reset mid-frame: pulse nrst low during data bit 4 of 0xC3 → outputs take reset values, no valid. The following frame 0x81 is received correctly.
